// File: rtl/vector_logic_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit.
// One request in flight; result returned with requester ID.
module vector_logic_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 8,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_op,
    input  logic [SIZE*NUM_REQ-1:0] req_a,
    input  logic [SIZE*NUM_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [SIZE-1:0]         rsp_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] id_q;
    logic            found;
    logic [1:0]      sel_op;
    logic [SIZE-1:0] sel_a;
    logic [SIZE-1:0] sel_b;
    logic [1:0]      op_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] result;
    logic            take;

    // Two passes: indices at or above rr_ptr first, then wrap to the lowest.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                found   = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end

    assign take = (state == IDLE) && found && !rst;

    always_comb begin
        req_ready = '0;
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                req_ready[i] = take;
                sel_op       = req_op[2*i +: 2];
                sel_a        = req_a[SIZE*i +: SIZE];
                sel_b        = req_b[SIZE*i +: SIZE];
            end
        end
    end

    always_comb begin
        result = '0;
        unique case (op_q)
            2'd0: result = a_q & b_q;
            2'd1: result = a_q | b_q;
            2'd2: result = a_q ^ b_q;
            2'd3: result = ~a_q;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        id_q <= gnt_idx;
                        op_q <= sel_op;
                        a_q  <= sel_a;
                        b_q  <= sel_b;
                    end
                end
                EXEC: begin
                    rsp_data  <= result;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    rr_ptr    <= (id_q == ID_W'(NUM_REQ - 1)) ?
                                 '0 : id_q + 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_vector_logic_arbiter.sv
// Directed self-checking bench for vector_logic_arbiter.
// Linear step sequence with immediate-assertion checks.
module tb_vector_logic_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [7:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;

    int total  = 0;
    int passed = 0;

    logic [7:0] exp_tab [4] = '{8'hF0, 8'h33, 8'h88, 8'hC3};

    vector_logic_arbiter #(
        .NUM_REQ(4),
        .SIZE(8),
        .ID_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_id"},    32'(rsp_id),    32'h0);
        chk({tag, "_data"},  32'(rsp_data),  32'h0);
        chk({tag, "_busy"},  32'(busy),      32'h0);
    endtask

    // One full transaction with rsp_ready already high.
    task automatic run_op(input string tag, input logic [3:0] mask,
                          input logic [3:0] gnt, input logic [1:0] id,
                          input logic [7:0] data);
        req_valid = mask;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'(gnt));
        chk({tag, "_idle"},  32'(busy),      32'h0);
        step();
        req_valid = req_valid & ~gnt;
        chk({tag, "_exec_busy"},  32'(busy),      32'h1);
        chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_exec_ready"}, 32'(req_ready), 32'h0);
        step();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'(data));
        step();
        chk({tag, "_done_busy"},  32'(busy),      32'h0);
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_done_data"},  32'(rsp_data),  32'(data));
    endtask

    initial begin
        req_valid = 4'b1111;
        #2;
        chk_zero("reset");
        step();
        chk_zero("reset_hold");
        rst = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;

        // AND on requester 0
        req_op = {2'd0, 2'd0, 2'd0, 2'd0};
        req_a  = {8'h00, 8'h00, 8'h00, 8'hF0};
        req_b  = {8'h00, 8'h00, 8'h00, 8'h3C};
        run_op("and0", 4'b0001, 4'b0001, 2'd0, 8'h30);

        // Opcode sweep on requester 2
        req_a = {8'h00, 8'hA5, 8'h00, 8'h00};
        req_b = {8'h00, 8'h0F, 8'h00, 8'h00};
        req_op = {2'd0, 2'd1, 2'd0, 2'd0};
        run_op("or2", 4'b0100, 4'b0100, 2'd2, 8'hAF);
        req_op = {2'd0, 2'd2, 2'd0, 2'd0};
        run_op("xor2", 4'b0100, 4'b0100, 2'd2, 8'hAA);
        req_op = {2'd0, 2'd3, 2'd0, 2'd0};
        run_op("not2", 4'b0100, 4'b0100, 2'd2, 8'h5A);

        // All requesters valid from a fresh reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req_op = {2'd3, 2'd0, 2'd1, 2'd2};
        req_a  = {8'h3C, 8'hCC, 8'h12, 8'h0F};
        req_b  = {8'h00, 8'hAA, 8'h21, 8'hFF};
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
            step();
            chk("rr_exec_ready", 32'(req_ready), 32'h0);
            step();
            chk("rr_onehot", 32'($countones(req_ready)), 32'h0);
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_data", 32'(rsp_data), 32'(exp_tab[k % 4]));
            step();
        end
        req_valid = 4'b0000;
        #1;

        // Backpressure; rr_ptr is 2, so requester 0 wins
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0110;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id",    32'(rsp_id),    32'h0);
            chk("bp_data",  32'(rsp_data),  32'hF0);
            chk("bp_ready", 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0100;
        step();
        chk("bp_next_id",   32'(rsp_id),   32'h1);
        chk("bp_next_data", 32'(rsp_data), 32'h33);
        step();
        req_valid = 4'b0000;

        // Reset during EXEC
        req_valid = 4'b1000;
        #1;
        chk("rx_grant", 32'(req_ready), 32'h8);
        step();
        chk("rx_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk_zero("rst_exec");
        step();
        rst = 1'b0;
        req_valid = 4'b0000;
        step();
        chk("rx_no_stale", 32'(rsp_valid), 32'h0);
        chk("rx_idle", 32'(busy), 32'h0);
        run_op("rx_after", 4'b1010, 4'b0010, 2'd1, 8'h33);

        // Reset during RESP; rr_ptr is 2, requester 3 still valid
        rsp_ready = 1'b0;
        #1;
        chk("rr2_grant", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'b0000;
        step();
        chk("rr2_valid", 32'(rsp_valid), 32'h1);
        chk("rr2_data",  32'(rsp_data),  32'hC3);
        rst = 1'b1;
        #1;
        chk_zero("rst_resp");
        step();
        rst = 1'b0;
        step();
        chk("rr2_no_stale", 32'(rsp_valid), 32'h0);
        step();
        chk("rr2_no_stale2", 32'(rsp_valid), 32'h0);
        rsp_ready = 1'b1;
        run_op("rr2_after", 4'b1100, 4'b0100, 2'd2, 8'h88);

        // Requester 3 pulses while in RESP; rr_ptr is 3
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("pulse_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        step();
        req_valid = 4'b1000;
        #1;
        chk("pulse_ready", 32'(req_ready), 32'h0);
        chk("pulse_id",    32'(rsp_id),    32'h0);
        chk("pulse_data",  32'(rsp_data),  32'hF0);
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        step();
        chk("pulse_idle",  32'(busy),      32'h0);
        chk("pulse_valid", 32'(rsp_valid), 32'h0);
        step();
        chk("pulse_nocap", 32'(busy),      32'h0);
        step();
        chk("pulse_norsp", 32'(rsp_valid), 32'h0);
        chk("pulse_keep",  32'(rsp_id),    32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vector_logic_arbiter.md
Name: vector_logic_arbiter

Overview:
- Shares one runtime-selectable bitwise logic unit (AND/OR/XOR/NOT) between NUM_REQ requesters.
- Grants requesters in round-robin order, captures the winner's operands and opcode, and computes a registered result.
- Returns the result with the requester ID on one shared response channel using a valid/ready handshake.
- Sits between the fabric's control logic and the vector logic resource, replacing per-client fixed-operation instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIZE, 8, operand/result width in bits.
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_op  input  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]. Encoding: 0 AND, 1 OR, 2 XOR, 3 NOT(a).
- req_a  input  SIZE*NUM_REQ  per-requester operand a, slice i.
- req_b  input  SIZE*NUM_REQ  per-requester operand b, slice i; ignored for NOT.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- rsp_data  output  SIZE  operation result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces the following, regardless of state, including mid-operation:
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - Any in-flight operation is discarded; no response is produced for it.
- FSM states:
  - IDLE: if any req_valid, the granted bit of req_ready is high this cycle (combinational from req_valid and rr_ptr). On the handshake, latch op/a/b from slice g, latch g into the ID register, go to EXEC. With no req_valid, stay in IDLE with req_ready = 0.
  - EXEC: compute the result from the latched op/a/b, register it into rsp_data, set rsp_valid = 1, set rr_ptr = (g+1) mod NUM_REQ, go to RESP.
  - RESP: hold rsp_valid, rsp_id and rsp_data stable until rsp_ready = 1. On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE. rsp_data/rsp_id keep their last values after the response is accepted.
- Arbitration:
  - Search starts at index rr_ptr and proceeds upward with wrap-around; the first asserted req_valid wins.
  - req_ready is 0 in EXEC and RESP, so no request is accepted while busy.
- Requester rules: once req_valid is asserted, the requester holds it and its op/a/b slices stable until req_ready. The block must tolerate req_valid dropping without a handshake; no capture occurs in that case.
- Timing:
  - Request handshake in cycle N; rsp_valid first high in cycle N+2.
  - If rsp_ready is already high at N+2, IDLE is re-entered at N+3.
  - Peak throughput is one operation per 3 cycles.
- Arithmetic: purely bitwise at width SIZE, no carry. NOT = ~a.
- busy = (state != IDLE).
- Simultaneous events:
  - All requesters valid: grant order is 0,1,2,3,0,… from reset.
  - A requester that re-asserts immediately after being served waits behind all other pending requesters.
- Illegal FSM encodings recover to IDLE.

Test Plan:
- Reset then req_valid=0001, op0=0, a0=8'hF0, b0=8'h3C → req_ready=0001 in cycle N; rsp_valid at N+2 with rsp_id=0, rsp_data=8'h30; rsp_ready=1 → back to IDLE, busy=0 at N+3.
- Opcode sweep on requester 2 with a=8'hA5, b=8'h0F → OR 8'hAF, XOR 8'hAA, NOT 8'h5A; each with rsp_id=2.
- req_valid=1111 held continuously, rsp_ready=1 → grants in order 0,1,2,3,0,1; never two req_ready bits high at once.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_id and rsp_data stable throughout; req_ready=0000 although req_valid=0110; after rsp_ready=1, the next grant goes to requester 1.
- Assert rst in EXEC, then in RESP → all outputs zero immediately (asynchronously); after release, the first grant goes to the lowest valid index (rr_ptr=0); no stale response appears.
- Requester 3 pulses req_valid for one cycle while the block is in RESP → no capture and no response for requester 3.
